// File: rtl/sfq_rx_pkg.sv
// Shared types and constants for the SFQ AND-cell capture stage.
package sfq_rx_pkg;
  typedef enum logic [1:0] {IDLE, OPEN, CLOSED} rx_state_e;
  localparam int SYNC_STAGES = 2;
  // Line toggle to pulse consumed by the FSM, in clk cycles.
  localparam int DETECT_LAT  = 3;
endpackage

// File: rtl/sfq_edge_detect.sv
// Toggle-line edge detector: synchronizer, history flop, XOR.
module sfq_edge_detect
  import sfq_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic pulse
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], line};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign pulse = sync[SYNC_STAGES-1] ^ hist;
endmodule

// File: rtl/sfq_and_deserializer.sv
// Decides one bit per SFQ clock period, packs WIDTH-bit words, buffers them in a FIFO.
module sfq_and_deserializer
  import sfq_rx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LATE_MAX   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sfq_clk,
  input  logic                     sfq_data,
  output logic [WIDTH-1:0]         word_out,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     err_orphan,
  output logic                     err_double,
  output logic                     err_late,
  output logic                     overflow
);
  localparam int BW = $clog2(WIDTH);
  localparam int AW = $clog2(LATE_MAX + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic clk_p, dat_p;

  sfq_edge_detect u_clk_det (.clk(clk), .rst(rst), .line(sfq_clk),  .pulse(clk_p));
  sfq_edge_detect u_dat_det (.clk(clk), .rst(rst), .line(sfq_data), .pulse(dat_p));

  rx_state_e        state;
  logic [AW-1:0]    age;
  logic             cur;
  logic [WIDTH-1:0] shreg, next_word, push_word;
  logic             push_q;
  logic             data_bit;

  // A data pulse is judged against the pre-update state, so a pulse landing
  // with the next clock pulse still counts toward the closing period.
  always_comb begin
    data_bit = cur;
    if (dat_p && state == OPEN) data_bit = 1'b1;
    next_word = shreg;
    next_word[bit_cnt] = data_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      age        <= '0;
      cur        <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      push_q     <= 1'b0;
      push_word  <= '0;
      err_orphan <= 1'b0;
      err_double <= 1'b0;
      err_late   <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (dat_p) begin
        case (state)
          IDLE:    err_orphan <= 1'b1;
          OPEN:    if (cur) err_double <= 1'b1;
          CLOSED:  err_late <= 1'b1;
          default: ;
        endcase
      end
      if (clk_p) begin
        state <= OPEN;
        age   <= '0;
        cur   <= 1'b0;
        if (state != IDLE) begin
          shreg <= next_word;
          if (bit_cnt == BW'(WIDTH - 1)) begin
            bit_cnt   <= '0;
            push_q    <= 1'b1;
            push_word <= next_word;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      end else begin
        cur <= data_bit;
        if (state == OPEN) begin
          if (age != AW'(LATE_MAX)) age <= age + 1'b1;
          // Closing here keeps a pulse LATE_MAX cycles after the clock inside the window.
          if (age == AW'(LATE_MAX - 1)) state <= CLOSED;
        end
      end
    end
  end

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;
  logic             full, pop, push_ok;

  assign full       = (count == (PW+1)'(FIFO_DEPTH));
  assign word_valid = (count != '0);
  assign pop        = word_valid && word_ready;
  assign push_ok    = push_q && (!full || pop);
  assign word_out   = word_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (push_q && !push_ok) overflow <= 1'b1;
    end
  end
endmodule
